// File: rtl/hqm_list_sel_rf_fifo_ctl_4x25.sv
// 6-deep in-order FIFO: 4 entries in an external 1-cycle-read RF plus a 2-entry output stage.
// Define HQM_LIST_SEL_RF_FIFO_ERR_CHK_EN to build the sticky overflow/underflow flags.
module hqm_list_sel_rf_fifo_ctl_4x25 #(
   parameter int DWIDTH = 25
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   output logic              push_ready,
   output logic              pop_valid,
   output logic [DWIDTH-1:0] pop_data,
   input  logic              pop,
   output logic              mem_we,
   output logic [1:0]        mem_waddr,
   output logic [DWIDTH-1:0] mem_wdata,
   output logic              mem_re,
   output logic [1:0]        mem_raddr,
   input  logic [DWIDTH-1:0] mem_rdata,
   output logic [2:0]        depth,
   output logic              err_ovf,
   output logic              err_unf
);

   logic [1:0]             wptr, rptr;
   logic [2:0]             ram_cnt;
   logic                   rd_inflight;
   logic [1:0]             out_cnt;
   logic [1:0][DWIDTH-1:0] out_q;
   logic                   push_acc, pop_acc, ld_slot;
   logic [2:0]             out_occ;

   assign push_ready = (ram_cnt < 3'd4);
   // Gate with rst_n so a push held across reset never strobes the RF.
   assign push_acc   = push & push_ready & rst_n;
   assign pop_valid  = (out_cnt != 2'd0);
   assign pop_acc    = pop & pop_valid;

   // Output-stage slots already claimed once this cycle's pop retires.
   assign out_occ = {1'b0, out_cnt} + {2'b00, rd_inflight} - {2'b00, pop_acc};
   assign mem_re  = (ram_cnt != 3'd0) && (out_occ < 3'd2);

   assign mem_we    = push_acc;
   assign mem_waddr = wptr;
   assign mem_wdata = push_data;
   assign mem_raddr = rptr;
   assign pop_data  = out_q[0];
   assign depth     = ram_cnt + {2'b00, rd_inflight} + {1'b0, out_cnt};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr        <= 2'd0;
         rptr        <= 2'd0;
         ram_cnt     <= 3'd0;
         rd_inflight <= 1'b0;
      end else begin
         if (push_acc) wptr <= wptr + 2'd1;
         if (mem_re)   rptr <= rptr + 2'd1;
         case ({push_acc, mem_re})
            2'b10:   ram_cnt <= ram_cnt + 3'd1;
            2'b01:   ram_cnt <= ram_cnt - 3'd1;
            default: ram_cnt <= ram_cnt;
         endcase
         rd_inflight <= mem_re;
      end
   end

   // Returning RF data lands behind whatever survives this cycle's pop.
   assign ld_slot = pop_acc ? out_cnt[1] : (out_cnt[1] | out_cnt[0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_cnt <= 2'd0;
         out_q   <= '0;
      end else begin
         out_cnt <= out_cnt + {1'b0, rd_inflight} - {1'b0, pop_acc};
         if (pop_acc)     out_q[0]       <= out_q[1];
         if (rd_inflight) out_q[ld_slot] <= mem_rdata;
      end
   end

`ifdef HQM_LIST_SEL_RF_FIFO_ERR_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
      end else begin
         if (push && !push_ready) err_ovf <= 1'b1;
         if (pop && !pop_valid)   err_unf <= 1'b1;
      end
   end
`else
   assign err_ovf = 1'b0;
   assign err_unf = 1'b0;
`endif

endmodule

// File: tb/tb_hqm_list_sel_rf_fifo_ctl_4x25.sv
// Bench for hqm_list_sel_rf_fifo_ctl_4x25: vector table, corner sequences, random vs queue model.
module tb_hqm_list_sel_rf_fifo_ctl_4x25;

`ifdef HQM_LIST_SEL_RF_FIFO_ERR_CHK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif
   localparam logic [24:0] A = 25'h1ABCDEF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        push = 1'b0, pop = 1'b0;
   logic [24:0] push_data = '0;
   logic        push_ready, pop_valid, mem_we, mem_re, err_ovf, err_unf;
   logic [24:0] pop_data, mem_wdata, mem_rdata;
   logic [1:0]  mem_waddr, mem_raddr;
   logic [2:0]  depth;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   hqm_list_sel_rf_fifo_ctl_4x25 #(.DWIDTH(25)) dut (
      .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .push_ready(push_ready),
      .pop_valid(pop_valid), .pop_data(pop_data), .pop(pop), .mem_we(mem_we),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_raddr(mem_raddr),
      .mem_rdata(mem_rdata), .depth(depth), .err_ovf(err_ovf), .err_unf(err_unf)
   );

   // External register file: synchronous write, one-cycle read latency, never cleared.
   logic [24:0] rf [4];
   initial mem_rdata = '0;
   always @(posedge clk) begin
      if (mem_we) rf[mem_waddr] <= mem_wdata;
      if (mem_re) mem_rdata <= rf[mem_raddr];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      logic push; logic [24:0] d; logic pop;
      logic we; logic [1:0] wa; logic re; logic [1:0] ra;
      logic pv; logic [24:0] pd; logic [2:0] dep; logic rdy; logic ovf; logic unf;
   } vec_t;
   vec_t tbl [16];

   logic [24:0] q [$];
   int re_cnt, n;

   initial begin
      // Fill past capacity with no pops, drain in order, then pop an empty FIFO.
      tbl[0]  = '{1, A,     0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      tbl[1]  = '{1, 25'd1, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0};
      tbl[2]  = '{1, 25'd2, 0, 1, 2, 1, 1, 0, 0, 2, 1, 0, 0};
      tbl[3]  = '{1, 25'd3, 0, 1, 3, 0, 0, 1, A, 3, 1, 0, 0};
      tbl[4]  = '{1, 25'd4, 0, 1, 0, 0, 0, 1, A, 4, 1, 0, 0};
      tbl[5]  = '{1, 25'd5, 0, 1, 1, 0, 0, 1, A, 5, 1, 0, 0};
      tbl[6]  = '{1, 25'd6, 0, 0, 0, 0, 0, 1, A, 6, 0, 0, 0};
      tbl[7]  = '{0, 25'd0, 0, 0, 0, 0, 0, 1, A, 6, 0, ERR_EN, 0};
      tbl[8]  = '{0, 25'd0, 1, 0, 0, 1, 2, 1, A, 6, 0, ERR_EN, 0};
      tbl[9]  = '{0, 25'd0, 1, 0, 0, 1, 3, 1, 25'd1, 5, 1, ERR_EN, 0};
      tbl[10] = '{0, 25'd0, 1, 0, 0, 1, 0, 1, 25'd2, 4, 1, ERR_EN, 0};
      tbl[11] = '{0, 25'd0, 1, 0, 0, 1, 1, 1, 25'd3, 3, 1, ERR_EN, 0};
      tbl[12] = '{0, 25'd0, 1, 0, 0, 0, 0, 1, 25'd4, 2, 1, ERR_EN, 0};
      tbl[13] = '{0, 25'd0, 1, 0, 0, 0, 0, 1, 25'd5, 1, 1, ERR_EN, 0};
      tbl[14] = '{0, 25'd0, 1, 0, 0, 0, 0, 0, 25'd0, 0, 1, ERR_EN, 0};
      tbl[15] = '{0, 25'd0, 0, 0, 0, 0, 0, 0, 25'd0, 0, 1, ERR_EN, ERR_EN};

      // Reset values
      do_reset();
      @(negedge clk);
      chk("rst_ready", 32'(push_ready), 1);
      chk("rst_pv", 32'(pop_valid), 0);
      chk("rst_depth", 32'(depth), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_re", 32'(mem_re), 0);
      chk("rst_pd", 32'(pop_data), 0);
      chk("rst_ovf", 32'(err_ovf), 0);
      chk("rst_unf", 32'(err_unf), 0);
      step();

      // Vector table
      do_reset();
      for (int i = 0; i < 16; i++) begin
         push = tbl[i].push; push_data = tbl[i].d; pop = tbl[i].pop;
         @(negedge clk);
         chk($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(tbl[i].we));
         if (tbl[i].we) chk($sformatf("tbl%0d_waddr", i), 32'(mem_waddr), 32'(tbl[i].wa));
         chk($sformatf("tbl%0d_re", i), 32'(mem_re), 32'(tbl[i].re));
         if (tbl[i].re) chk($sformatf("tbl%0d_raddr", i), 32'(mem_raddr), 32'(tbl[i].ra));
         chk($sformatf("tbl%0d_pv", i), 32'(pop_valid), 32'(tbl[i].pv));
         if (tbl[i].pv) chk($sformatf("tbl%0d_pd", i), 32'(pop_data), 32'(tbl[i].pd));
         chk($sformatf("tbl%0d_depth", i), 32'(depth), 32'(tbl[i].dep));
         chk($sformatf("tbl%0d_ready", i), 32'(push_ready), 32'(tbl[i].rdy));
         chk($sformatf("tbl%0d_ovf", i), 32'(err_ovf), 32'(tbl[i].ovf));
         chk($sformatf("tbl%0d_unf", i), 32'(err_unf), 32'(tbl[i].unf));
         step();
      end
      push = 1'b0; pop = 1'b0;

      // Streaming: push and pop every cycle, 3-cycle latency then no bubbles
      do_reset();
      for (int c = 0; c < 23; c++) begin
         push = (c < 20); push_data = 25'(c); pop = 1'b1;
         @(negedge clk);
         if (c < 3) chk($sformatf("stream%0d_pv", c), 32'(pop_valid), 0);
         else begin
            chk($sformatf("stream%0d_pv", c), 32'(pop_valid), 1);
            chk($sformatf("stream%0d_pd", c), 32'(pop_data), 32'(c - 3));
         end
         step();
      end
      push = 1'b0; pop = 1'b0;
      @(negedge clk);
      chk("stream_depth_end", 32'(depth), 0);
      step();

      // Backpressure: full FIFO held, then a single pop
      do_reset();
      for (int i = 0; i < 6; i++) begin
         push = 1'b1; push_data = 25'(10 + i);
         @(negedge clk);
         step();
      end
      push = 1'b0;
      re_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         re_cnt += 32'(mem_re);
         step();
      end
      chk("bp_hold_re", 32'(re_cnt), 0);
      chk("bp_hold_depth", 32'(depth), 6);
      pop = 1'b1;
      @(negedge clk);
      chk("bp_head", 32'(pop_data), 10);
      re_cnt = 32'(mem_re);
      step();
      pop = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         re_cnt += 32'(mem_re);
         step();
      end
      @(negedge clk);
      chk("bp_one_re", 32'(re_cnt), 1);
      chk("bp_next", 32'(pop_data), 11);
      chk("bp_depth", 32'(depth), 5);
      step();

      // Reset while a read is in flight
      do_reset();
      push = 1'b1; push_data = 25'd7;
      @(negedge clk);
      step();
      push = 1'b0;
      @(negedge clk);
      chk("rif_re", 32'(mem_re), 1);
      step();
      rst_n = 1'b0; push = 1'b1; push_data = 25'd9; pop = 1'b1;
      @(negedge clk);
      chk("rif_rst_ready", 32'(push_ready), 1);
      chk("rif_rst_pv", 32'(pop_valid), 0);
      chk("rif_rst_we", 32'(mem_we), 0);
      chk("rif_rst_re", 32'(mem_re), 0);
      chk("rif_rst_depth", 32'(depth), 0);
      chk("rif_rst_pd", 32'(pop_data), 0);
      step();
      step();
      rst_n = 1'b1; push = 1'b0; pop = 1'b0;
      @(negedge clk);
      chk("rif_depth", 32'(depth), 0);
      chk("rif_pv", 32'(pop_valid), 0);
      chk("rif_ready", 32'(push_ready), 1);
      step();
      push = 1'b1; push_data = 25'd5;
      @(negedge clk);
      step();
      push = 1'b0;
      n = 0;
      while (n < 8) begin
         @(negedge clk);
         if (pop_valid) break;
         step();
         n++;
      end
      chk("rif_wait_pv", 32'(pop_valid), 1);
      chk("rif_first", 32'(pop_data), 5);
      step();

      // Random traffic against a queue model
      do_reset();
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         int bias;
         bias = ((c / 300) % 2 == 0) ? 75 : 30;
         push = ($urandom_range(0, 99) < bias);
         pop  = ($urandom_range(0, 99) < (105 - bias));
         push_data = 25'($urandom);
         @(negedge clk);
         chk("rnd_depth", 32'(depth), 32'(q.size()));
         chk("rnd_we", 32'(mem_we), 32'(push & push_ready));
         if (q.size() < 4) chk("rnd_ready_low", 32'(push_ready), 1);
         if (q.size() == 6) chk("rnd_ready_full", 32'(push_ready), 0);
         if (q.size() == 0) chk("rnd_pv_empty", 32'(pop_valid), 0);
         if (mem_we && mem_re) chk("rnd_addr_clash", 32'(mem_waddr != mem_raddr), 1);
         if (pop && pop_valid) begin
            chk("rnd_order", 32'(pop_data), (q.size() != 0) ? 32'(q[0]) : 32'hFFFF_FFFF);
            if (q.size() != 0) void'(q.pop_front());
         end
         if (push && push_ready) q.push_back(push_data);
         step();
      end
      push = 1'b0; pop = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
